decode_ctrl_stage: RTL and testbench
====================================

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2: cycles the MUL/DIV unit stays busy after a multiply issue (1..255).
REQ-002 SHALL have parameter DIV_LAT, default 32: cycles busy after a divide/remainder issue (1..255).
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard held instruction.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- instr  in  32  RV32 instruction word.
- out_valid  out  1  decoded bundle valid to EX.
- out_ready  in  1  EX accepts bundle.
- reg_write, alu_src, mem_read, mem_write, branch, jump, jump_r, mem_to_reg, auipc  out  1 each  registered control flags.
- alu_op  out  2  00 add, 01 branch compare, 10 R-type funct decode, 11 LUI pass.
- md_valid  out  1  bundle is an M-extension op.
- md_op  out  3  funct3 of the M op.
- illegal  out  1  unrecognised encoding.
- md_busy  out  1  MUL/DIV occupancy counter non-zero.

Function
REQ-004 SHALL decode opcode/funct7 of instr and capture the bundle in one pipeline register on (in_valid && in_ready); latency 1 cycle.
REQ-005 SHALL decode: 0110011 R (reg_write, alu_op=10); 0010011 I-ALU (reg_write, alu_src); 0000011 load (reg_write, alu_src, mem_read, mem_to_reg); 0100011 store (alu_src, mem_write); 1100011 branch (branch, alu_op=01); 0110111 LUI (reg_write, alu_src, alu_op=11); 1101111 JAL (reg_write, jump, alu_src); 1100111 JALR (reg_write, jump_r, alu_src); 0010111 AUIPC (reg_write, auipc, alu_src); unlisted flags 0.
REQ-006 SHALL, for opcode 0110011, accept funct7 0000000 and 0100000 as ALU ops; funct7 0000001 SHALL set md_valid=1, md_op=funct3, alu_op=10, reg_write=1.
REQ-007 SHALL, for any other opcode or R-type funct7, set illegal=1 with all other control flags and md_valid 0; illegal bundles still pass through the handshake.
REQ-008 SHALL track full (register holds a bundle); out_valid = full && !(md_valid && md_busy).
REQ-009 SHALL drive in_ready = !flush && (!full || (out_valid && out_ready)).
REQ-010 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-011 SHALL keep an 8-bit occupancy counter, FSM states MD_IDLE (count 0) and MD_BUSY (count > 0).
REQ-012 SHALL, on an output transfer with md_valid, load MUL_LAT if md_op[2]=0 else DIV_LAT, entering MD_BUSY.
REQ-013 SHALL otherwise decrement count by 1 each cycle in MD_BUSY, returning to MD_IDLE on reaching 0; md_busy = (count != 0).
REQ-014 SHALL let non-M bundles transfer while MD_BUSY.
REQ-015 SHALL, when flush=1, clear full at the next edge, drop any simultaneous input, and leave the counter unaffected.
REQ-016 SHALL give flush priority over a simultaneous out_ready transfer: no transfer, no counter load.

Reset
REQ-017 SHALL, on rst_n low, asynchronously clear full, count, out_valid, every control flag, alu_op, md_op, md_valid, illegal and md_busy to 0; in_ready SHALL be 1 from the first edge after release (flush low).

Configuration
REQ-018 SHALL honour macro RV32M_EN: defined -> REQ-006 and REQ-011..013 apply; undefined -> funct7 0000001 decodes illegal, counter absent, md_valid/md_op/md_busy tied 0.

Structure
REQ-019 SHALL place opcode constants, alu_op encodings and the control-bundle struct in shared package rv32_ctrl_pkg.
REQ-020 SHALL implement the combinational decoder as sub-module rv32_ctrl_decode, instantiated once; register, handshake and counter live in the top.

Verification
REQ-021 SHALL: reset, issue addi (0x00500093) with out_ready=1 -> out_valid next cycle, reg_write=1, alu_src=1, alu_op=00.
REQ-022 SHALL: out_ready=0 with lw queued -> bundle held stable, in_ready=0, second instr not captured until out_ready=1.
REQ-023 SHALL: mul (funct7=0000001, funct3=000) transfer, then mul immediately -> second out_valid low for exactly 2 cycles, md_busy high 2 cycles.
REQ-024 SHALL: div (funct3=100) then add then div -> add transfers during busy; second div waits until 32 cycles after first.
REQ-025 SHALL: flush asserted with full=1 and in_valid=1 -> full cleared, input dropped, counter continues decrementing.
REQ-026 SHALL: opcode 0x7F and rst_n pulsed mid-MD_BUSY -> illegal=1 with flags 0; reset returns count and all outputs to 0 asynchronously.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared opcode constants, alu_op encodings and the decoded control bundle
// for the RV32 decode/control stage.
package rv32_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_LUI    = 2'b11
   } alu_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       jump_r;
      logic       mem_to_reg;
      logic       auipc;
      alu_op_e    alu_op;
      logic       md_valid;
      logic [2:0] md_op;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/rv32_ctrl_decode.sv
// Combinational RV32I(+M) control decoder: instruction word -> control bundle.
// M-extension decode is present only when RV32M_EN is defined.
module rv32_ctrl_decode
   import rv32_ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output ctrl_t       ctrl
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Register and immediate fields are consumed downstream, not here.
`ifdef RV32M_EN
   logic unused_fields;
   assign unused_fields = ^{instr[24:15], instr[11:7]};
`else
   logic unused_fields;
   assign unused_fields = ^{instr[24:15], instr[11:7], funct3};
`endif

   always_comb begin
      // NOTE: the default assignment up front covers every path, so no latch is inferred.
      ctrl = CTRL_NOP;
      case (opcode)
         OP_R: begin
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_op    = ALU_FUNCT;
            end
`ifdef RV32M_EN
            else if (funct7 == F7_MULDIV) begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_op    = ALU_FUNCT;
               ctrl.md_valid  = 1'b1;
               ctrl.md_op     = funct3;
            end
`endif
            else begin
               ctrl.illegal = 1'b1;
            end
         end
         OP_I_ALU: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_STORE: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BRANCH: begin
            ctrl.branch = 1'b1;
            ctrl.alu_op = ALU_BRANCH;
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.alu_op    = ALU_LUI;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump      = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.jump_r    = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.auipc     = 1'b1;
            ctrl.alu_src   = 1'b1;
         end
         default: ctrl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode/control pipeline stage: one-entry bundle register with valid/ready
// handshake, flush, and a MUL/DIV occupancy counter (enabled by RV32M_EN).
module decode_ctrl_stage
   import rv32_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 2,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        reg_write,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        branch,
   output logic        jump,
   output logic        jump_r,
   output logic        mem_to_reg,
   output logic        auipc,
   output logic [1:0]  alu_op,
   output logic        md_valid,
   output logic [2:0]  md_op,
   output logic        illegal,
   output logic        md_busy
);

   ctrl_t dec_ctrl;
   ctrl_t ctrl_q;
   logic  full;
   logic  accept;
   logic  xfer;

   rv32_ctrl_decode u_decode (
      .instr (instr),
      .ctrl  (dec_ctrl)
   );

   // Flush wins over a pending output transfer: nothing leaves on a flush cycle.
   assign xfer     = out_valid && out_ready && !flush;
   assign in_ready = !flush && (!full || (out_valid && out_ready));
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the bundle register is reset too, so every output reads 0 while rst_n is low.
      if (!rst_n) begin
         full   <= 1'b0;
         ctrl_q <= CTRL_NOP;
      end else if (flush) begin
         full <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
         full   <= 1'b1;
         ctrl_q <= dec_ctrl;
      end else if (xfer) begin
         full <= 1'b0;
      end
   end

   assign reg_write  = ctrl_q.reg_write;
   assign alu_src    = ctrl_q.alu_src;
   assign mem_read   = ctrl_q.mem_read;
   assign mem_write  = ctrl_q.mem_write;
   assign branch     = ctrl_q.branch;
   assign jump       = ctrl_q.jump;
   assign jump_r     = ctrl_q.jump_r;
   assign mem_to_reg = ctrl_q.mem_to_reg;
   assign auipc      = ctrl_q.auipc;
   assign alu_op     = ctrl_q.alu_op;
   assign illegal    = ctrl_q.illegal;

`ifdef RV32M_EN
   md_state_e  md_state;
   logic [7:0] count;
   logic       busy_q;

   assign md_valid  = ctrl_q.md_valid;
   assign md_op     = ctrl_q.md_op;
   assign md_busy   = busy_q;
   // An M bundle may only leave once the unit has drained.
   assign out_valid = full && !(ctrl_q.md_valid && busy_q);

   // busy_q mirrors (count != 0) as a registered flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_state <= MD_IDLE;
         count    <= 8'd0;
         busy_q   <= 1'b0;
      end else if (xfer && ctrl_q.md_valid) begin
         md_state <= MD_BUSY;
         count    <= ctrl_q.md_op[2] ? 8'(DIV_LAT) : 8'(MUL_LAT);
         busy_q   <= 1'b1;
      end else if (md_state == MD_BUSY) begin
         count <= count - 8'd1;
         if (count == 8'd1) begin
            md_state <= MD_IDLE;
            busy_q   <= 1'b0;
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{ctrl_q.md_valid, ctrl_q.md_op, 8'(MUL_LAT), 8'(DIV_LAT)};

   assign md_valid  = 1'b0;
   assign md_op     = 3'b000;
   assign md_busy   = 1'b0;
   assign out_valid = full;
`endif

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench for decode_ctrl_stage; M-extension sequences
// are exercised when RV32M_EN is defined, otherwise M encodings must be illegal.
module tb_decode_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic        reg_write, alu_src, mem_read, mem_write, branch;
   logic        jump, jump_r, mem_to_reg, auipc;
   logic [1:0]  alu_op;
   logic        md_valid;
   logic [2:0]  md_op;
   logic        illegal;
   logic        md_busy;

   int vectors = 0;
   int miscompares = 0;

   decode_ctrl_stage #(.MUL_LAT(2), .DIV_LAT(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr      (instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .reg_write  (reg_write),
      .alu_src    (alu_src),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .branch     (branch),
      .jump       (jump),
      .jump_r     (jump_r),
      .mem_to_reg (mem_to_reg),
      .auipc      (auipc),
      .alu_op     (alu_op),
      .md_valid   (md_valid),
      .md_op      (md_op),
      .illegal    (illegal),
      .md_busy    (md_busy)
   );

   always #5 clk = ~clk;

   // {reg_write, alu_src, mem_read, mem_write, branch, jump, jump_r, mem_to_reg, auipc, alu_op, md_valid, md_op, illegal}
   logic [15:0] bundle;
   assign bundle = {reg_write, alu_src, mem_read, mem_write, branch, jump, jump_r,
                    mem_to_reg, auipc, alu_op, md_valid, md_op, illegal};

   localparam logic [15:0] B_ADDI  = 16'hC000;
   localparam logic [15:0] B_LOAD  = 16'hE100;
   localparam logic [15:0] B_STORE = 16'h5000;
   localparam logic [15:0] B_BR    = 16'h0820;
   localparam logic [15:0] B_R     = 16'h8040;
   localparam logic [15:0] B_LUI   = 16'hC060;
   localparam logic [15:0] B_JAL   = 16'hC400;
   localparam logic [15:0] B_JALR  = 16'hC200;
   localparam logic [15:0] B_AUIPC = 16'hC080;
   localparam logic [15:0] B_ILL   = 16'h0001;
   localparam logic [15:0] B_MUL   = 16'h8050;
   localparam logic [15:0] B_DIV   = 16'h8058;

   localparam logic [31:0] I_ADDI  = 32'h0050_0093;
   localparam logic [31:0] I_LW    = 32'h0000_A103;
   localparam logic [31:0] I_SW    = 32'h0020_A023;
   localparam logic [31:0] I_BEQ   = 32'h0020_8063;
   localparam logic [31:0] I_ADD   = 32'h0020_81B3;
   localparam logic [31:0] I_SUB   = 32'h4020_81B3;
   localparam logic [31:0] I_LUI   = 32'h1234_50B7;
   localparam logic [31:0] I_JAL   = 32'h0000_00EF;
   localparam logic [31:0] I_JALR  = 32'h0001_00E7;
   localparam logic [31:0] I_AUIPC = 32'h0000_0097;
   localparam logic [31:0] I_BADF7 = 32'h2020_81B3;
   localparam logic [31:0] I_OP7F  = 32'h0000_007F;
   localparam logic [31:0] I_MUL   = 32'h0220_81B3;
   localparam logic [31:0] I_DIV   = 32'h0220_C1B3;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] v_instr [10];
   logic [15:0] v_exp   [10];
   int          n;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   initial begin
      v_instr[0] = I_SW;    v_exp[0] = B_STORE;
      v_instr[1] = I_BEQ;   v_exp[1] = B_BR;
      v_instr[2] = I_ADD;   v_exp[2] = B_R;
      v_instr[3] = I_SUB;   v_exp[3] = B_R;
      v_instr[4] = I_LUI;   v_exp[4] = B_LUI;
      v_instr[5] = I_JAL;   v_exp[5] = B_JAL;
      v_instr[6] = I_JALR;  v_exp[6] = B_JALR;
      v_instr[7] = I_AUIPC; v_exp[7] = B_AUIPC;
      v_instr[8] = I_BADF7; v_exp[8] = B_ILL;
      v_instr[9] = I_OP7F;  v_exp[9] = B_ILL;

      // Reset state, checked asynchronously before any clock edge.
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_bundle", 32'(bundle), 32'd0);
      chk("rst_md_busy", 32'(md_busy), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // addi with out_ready high: one cycle latency.
      in_valid = 1'b1; instr = I_ADDI; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("addi_out_valid", 32'(out_valid), 32'd1);
      chk("addi_bundle", 32'(bundle), 32'(B_ADDI));
      tick();
      chk("addi_drained", 32'(out_valid), 32'd0);

      // Back-to-back stream through every remaining opcode class.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; instr = v_instr[i];
         tick();
         chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d_bundle", i), 32'(bundle), 32'(v_exp[i]));
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drained", 32'(out_valid), 32'd0);

      // Backpressure: lw held stable, add not captured until out_ready.
      out_ready = 1'b0; in_valid = 1'b1; instr = I_LW;
      tick();
      instr = I_ADD;
      chk("bp_lw_valid", 32'(out_valid), 32'd1);
      chk("bp_lw_bundle", 32'(bundle), 32'(B_LOAD));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_hold%0d_bundle", i), 32'(bundle), 32'(B_LOAD));
         chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_add_bundle", 32'(bundle), 32'(B_R));
      tick();
      chk("bp_drained", 32'(out_valid), 32'd0);

`ifdef RV32M_EN
      // mul then mul: second waits exactly MUL_LAT cycles.
      in_valid = 1'b1; instr = I_MUL;
      tick();
      chk("mul1_valid", 32'(out_valid), 32'd1);
      chk("mul1_bundle", 32'(bundle), 32'(B_MUL));
      tick();
      in_valid = 1'b0;
      chk("mul2_stall0_valid", 32'(out_valid), 32'd0);
      chk("mul2_stall0_busy", 32'(md_busy), 32'd1);
      tick();
      chk("mul2_stall1_valid", 32'(out_valid), 32'd0);
      chk("mul2_stall1_busy", 32'(md_busy), 32'd1);
      tick();
      chk("mul2_release_valid", 32'(out_valid), 32'd1);
      chk("mul2_release_busy", 32'(md_busy), 32'd0);
      tick(); tick(); tick();
      chk("mul2_done_busy", 32'(md_busy), 32'd0);

      // div, add, div: add slips through while busy; second div waits 32 cycles.
      in_valid = 1'b1; instr = I_DIV;
      tick();
      chk("div1_bundle", 32'(bundle), 32'(B_DIV));
      instr = I_ADD;
      tick();
      chk("div_add_valid", 32'(out_valid), 32'd1);
      chk("div_add_bundle", 32'(bundle), 32'(B_R));
      chk("div_add_busy", 32'(md_busy), 32'd1);
      instr = I_DIV;
      tick();
      in_valid = 1'b0;
      chk("div2_stalled", 32'(out_valid), 32'd0);
      chk("div2_bundle", 32'(bundle), 32'(B_DIV));
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("div2_wait_cycles", 32'(n), 32'd31);
      tick();
      chk("div2_issued_busy", 32'(md_busy), 32'd1);
`endif

      // Flush with full=1 and a simultaneous input and out_ready.
      in_valid = 1'b1; instr = I_ADD;
      tick();
      chk("flush_pre_full", 32'(out_valid), 32'd1);
      flush = 1'b1; instr = I_LW;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_cleared", 32'(out_valid), 32'd0);
`ifdef RV32M_EN
      chk("flush_busy_kept", 32'(md_busy), 32'd1);
      n = 0;
      while (md_busy && n < 100) begin
         tick();
         n++;
      end
      chk("flush_count_drain", 32'(n), 32'd30);

      // Flush beats a ready M transfer: no counter load.
      in_valid = 1'b1; instr = I_MUL;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_md_no_load", 32'(md_busy), 32'd0);
      chk("flush_md_cleared", 32'(out_valid), 32'd0);

      // Enter MD_BUSY, then hold an illegal bundle for the reset test.
      in_valid = 1'b1; instr = I_DIV;
      tick();
      instr = I_OP7F;
      tick();
      chk("ill_busy", 32'(md_busy), 32'd1);
`else
      // M encodings decode illegal and never stall.
      in_valid = 1'b1; instr = I_MUL;
      tick();
      chk("nom_mul_bundle", 32'(bundle), 32'(B_ILL));
      tick();
      chk("nom_mul2_valid", 32'(out_valid), 32'd1);
      chk("nom_md_busy", 32'(md_busy), 32'd0);
      instr = I_OP7F;
      tick();
`endif
      in_valid = 1'b0; out_ready = 1'b0;
      chk("ill_valid", 32'(out_valid), 32'd1);
      chk("ill_bundle", 32'(bundle), 32'(B_ILL));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_bundle", 32'(bundle), 32'd0);
      chk("async_rst_busy", 32'(md_busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("rerst_in_ready", 32'(in_ready), 32'd1);
      chk("rerst_busy", 32'(md_busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
